// File: rtl/life_grid_engine.sv
// life_grid_engine
//   Game-of-life cell store and evolution engine feeding the VGA timing stage.
//   Two bit-banks hold an N x M toroidal grid. One bank is shown, the other is
//   the work bank. The next generation (B3/S23) is computed one cell per cycle
//   into the work bank. The banks swap roles only during vertical blanking.
//
// Ports
//   clk         in   1        system clock, posedge
//   rst_n       in   1        asynchronous active-low reset
//   pos         in   2*WIDTH  linear cell index requested by VGA (row*N + col)
//   vga_live    out  1        display-bank bit at pos, one cycle later
//   vblank      in   1        VGA is outside the visible field vertically
//   step        in   1        pulse: compute one generation
//   run         in   1        level: auto-step every PERIOD cycles
//   clear       in   1        pulse: zero the grid, return to idle
//   edit_we     in   1        write enable for seeding a cell (idle only)
//   edit_addr   in   2*WIDTH  linear cell index to write
//   edit_val    in   1        value written
//   busy        out  1        engine is not idle
//   generation  out  16       number of completed bank swaps
module life_grid_engine #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned P_PARAM_N = 32,
  parameter int unsigned P_PARAM_M = 24,
  parameter int unsigned PERIOD    = 25000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*WIDTH-1:0]   pos,
  output logic                 vga_live,
  input  logic                 vblank,
  input  logic                 step,
  input  logic                 run,
  input  logic                 clear,
  input  logic                 edit_we,
  input  logic [2*WIDTH-1:0]   edit_addr,
  input  logic                 edit_val,
  output logic                 busy,
  output logic [15:0]          generation
);

  localparam int unsigned NM = P_PARAM_N * P_PARAM_M;
  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned IW = $clog2(NM);
  localparam int unsigned CW = $clog2(P_PARAM_N);
  localparam int unsigned RW = $clog2(P_PARAM_M);
  localparam int unsigned PW = $clog2(PERIOD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_WAIT_SWAP,
    S_SWAP
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            sel_q, sel_d;
  logic [15:0]     gen_q, gen_d;
  logic            busy_q, busy_d;
  logic            live_q, live_d;
  logic [PW-1:0]   per_q, per_d;
  logic [NM-1:0]   bank0_q, bank0_d;
  logic [NM-1:0]   bank1_q, bank1_d;

  logic [NM-1:0]   disp;
  logic [RW-1:0]   r_up, r_dn;
  logic [CW-1:0]   c_lf, c_rt;
  logic [7:0]      nb;
  logic [3:0]      cnt;
  logic            new_cell;
  logic            auto_tick;
  logic            step_req;

  function automatic logic [IW-1:0] cell_idx(input logic [RW-1:0] r,
                                             input logic [CW-1:0] c);
    return IW'(r) * IW'(P_PARAM_N) + IW'(c);
  endfunction

  // sel_q=0 shows bank0 and evolves into bank1; sel_q=1 the reverse.
  assign disp = sel_q ? bank1_q : bank0_q;

  // Toroidal neighbour coordinates of the cell being evaluated.
  always_comb begin
    r_up = (row_q == '0) ? RW'(P_PARAM_M - 1) : row_q - RW'(1);
    r_dn = (row_q == RW'(P_PARAM_M - 1)) ? '0 : row_q + RW'(1);
    c_lf = (col_q == '0) ? CW'(P_PARAM_N - 1) : col_q - CW'(1);
    c_rt = (col_q == CW'(P_PARAM_N - 1)) ? '0 : col_q + CW'(1);
  end

  always_comb begin
    nb[0] = disp[cell_idx(r_up,  c_lf)];
    nb[1] = disp[cell_idx(r_up,  col_q)];
    nb[2] = disp[cell_idx(r_up,  c_rt)];
    nb[3] = disp[cell_idx(row_q, c_lf)];
    nb[4] = disp[cell_idx(row_q, c_rt)];
    nb[5] = disp[cell_idx(r_dn,  c_lf)];
    nb[6] = disp[cell_idx(r_dn,  col_q)];
    nb[7] = disp[cell_idx(r_dn,  c_rt)];
    cnt = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      cnt = cnt + 4'(nb[k]);
    end
    new_cell = (cnt == 4'd3) | (disp[idx_q] & (cnt == 4'd2));
  end

  // Auto-step timer: free-runs while run is high, parked at zero otherwise.
  always_comb begin
    auto_tick = run && (per_q == PW'(PERIOD - 1));
    per_d     = '0;
    if (run) begin
      per_d = auto_tick ? '0 : per_q + PW'(1);
    end
  end

  assign step_req = step | auto_tick;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    sel_d   = sel_q;
    gen_d   = gen_q;

    unique case (state_q)
      S_IDLE: begin
        if (step_req && !edit_we) begin
          state_d = S_CALC;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_CALC: begin
        if (idx_q == IW'(NM - 1)) begin
          state_d = S_WAIT_SWAP;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
          if (col_q == CW'(P_PARAM_N - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_WAIT_SWAP: begin
        if (vblank) begin
          state_d = S_SWAP;
        end
      end
      S_SWAP: begin
        sel_d   = ~sel_q;
        gen_d   = gen_q + 16'd1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Clear overrides whatever the state machine decided, including a swap.
    if (clear) begin
      state_d = S_IDLE;
      idx_d   = '0;
      row_d   = '0;
      col_d   = '0;
      sel_d   = sel_q;
      gen_d   = gen_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  // Bank writes: clear, then idle-time edits into the display bank, then
  // the evolution result into the work bank.
  always_comb begin
    bank0_d = bank0_q;
    bank1_d = bank1_q;
    if (clear) begin
      bank0_d = '0;
      bank1_d = '0;
    end else if (state_q == S_IDLE) begin
      if (edit_we && (edit_addr < AW'(NM))) begin
        if (sel_q) begin
          bank1_d[edit_addr[IW-1:0]] = edit_val;
        end else begin
          bank0_d[edit_addr[IW-1:0]] = edit_val;
        end
      end
    end else if (state_q == S_CALC) begin
      if (sel_q) begin
        bank0_d[idx_q] = new_cell;
      end else begin
        bank1_d[idx_q] = new_cell;
      end
    end
  end

  always_comb begin
    live_d = 1'b0;
    if (pos < AW'(NM)) begin
      live_d = disp[pos[IW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      sel_q   <= 1'b0;
      gen_q   <= '0;
      busy_q  <= 1'b0;
      live_q  <= 1'b0;
      per_q   <= '0;
      bank0_q <= '0;
      bank1_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sel_q   <= sel_d;
      gen_q   <= gen_d;
      busy_q  <= busy_d;
      live_q  <= live_d;
      per_q   <= per_d;
      bank0_q <= bank0_d;
      bank1_q <= bank1_d;
    end
  end

  assign vga_live   = live_q;
  assign busy       = busy_q;
  assign generation = gen_q;

endmodule
